// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit units.
// Holds the parity and baud encodings, the deframer state enum, the
// received-frame payload struct and the 16x tick divisor helper.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned DATA_W     = 8;

  // Parity encodings (2'b11 behaves as none)
  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;

  typedef enum logic [1:0] {
    BAUD_2400  = 2'b00,
    BAUD_4800  = 2'b01,
    BAUD_9600  = 2'b10,
    BAUD_19200 = 2'b11
  } baud_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Completed-frame payload presented to the byte consumer
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              parity_error;
    logic              stop_error;
  } uart_rx_result_t;

  // Clocks per oversample tick, truncated; never returns zero
  function automatic logic [DIV_W-1:0] uart_div(input int unsigned clk_freq,
                                                input baud_e       baud);
    int unsigned rate;
    int unsigned q;
    case (baud)
      BAUD_2400:  rate = 2400;
      BAUD_4800:  rate = 4800;
      BAUD_9600:  rate = 9600;
      BAUD_19200: rate = 19200;
      default:    rate = 2400;
    endcase
    q = clk_freq / (OVERSAMPLE * rate);
    if (q == 0) q = 1;
    return DIV_W'(q);
  endfunction

endpackage

// File: rtl/uart_rx_unit_if.sv
// Serial-line and byte-side signal bundle of the UART receiver.
//   data_rx      : serial line into the receiver (idles high)
//   parity_type  : 00 none, 01 odd, 10 even, 11 none
//   baud_rate    : 00 2400, 01 4800, 10 9600, 11 19200
//   data_out     : last received byte
//   active_flag  : frame in progress
//   done_flag    : one-clock frame-complete pulse
//   parity_error : parity mismatch in last frame
//   stop_error   : stop bit sampled low in last frame
// master = pin/consumer side, slave = receiver side.
interface uart_rx_unit_if;

  logic       data_rx;
  logic [1:0] parity_type;
  logic [1:0] baud_rate;
  logic [7:0] data_out;
  logic       active_flag;
  logic       done_flag;
  logic       parity_error;
  logic       stop_error;

  modport master (
    output data_rx, parity_type, baud_rate,
    input  data_out, active_flag, done_flag, parity_error, stop_error
  );

  modport slave (
    input  data_rx, parity_type, baud_rate,
    output data_out, active_flag, done_flag, parity_error, stop_error
  );

endinterface

// File: rtl/uart_rx_tick_gen.sv
// 16x-baud tick generator for the UART receiver.
//   clock   : system clock
//   reset_n : async active-low reset
//   i_clear : restart the divisor so ticks align to a start edge
//   i_baud  : baud code selecting the divisor
//   o_tick  : one-clock pulse every DIV clocks
module uart_rx_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic  clock,
  input  logic  reset_n,
  input  logic  i_clear,
  input  baud_e i_baud,
  output logic  o_tick
);

  logic [DIV_W-1:0] w_div;
  logic [DIV_W-1:0] w_last;
  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;

  assign w_div  = uart_div(CLK_FREQ, i_baud);
  assign w_last = w_div - DIV_W'(1);

  // Free-running divisor, restarted by i_clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt >= w_last) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + DIV_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_rx_unit.sv
// UART receiver: 16x oversampled deframer for start / 8 data (LSB first) /
// optional parity / stop, with registered byte, done and error outputs.
//   clock   : system clock, rising edge
//   reset_n : async active-low reset
//   rx      : uart_rx_unit_if.slave (serial line, config, byte and flags)
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic           clock,
  input  logic           reset_n,
  uart_rx_unit_if.slave  rx
);

  localparam int unsigned          TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0]    MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0]    LAST_TICK = TICK_W'(OVERSAMPLE - 1);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_prev;
  logic                w_line;
  logic                w_fall;
  logic                w_clear;
  logic                w_tick;
  logic                w_par_en;
  logic                w_par_exp;

  uart_state_e         r_state;
  baud_e               r_baud;
  logic [1:0]          r_parity;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [2:0]          r_bit_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par_err_pend;
  uart_rx_result_t     r_result;
  logic                r_active;
  logic                r_done;

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx.data_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_line  = r_sync2;
  // A held-low line never produces another falling edge, so breaks don't retrigger
  assign w_fall  = r_prev & ~r_sync2;
  assign w_clear = (r_state == IDLE) && w_fall;

  uart_rx_tick_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_tick_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clear (w_clear),
    .i_baud  (r_baud),
    .o_tick  (w_tick)
  );

  assign w_par_en  = (r_parity == PARITY_ODD) || (r_parity == PARITY_EVEN);
  assign w_par_exp = (^r_shift) ^ (r_parity == PARITY_ODD);

  // Deframing FSM with registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_baud         <= BAUD_2400;
      r_parity       <= PARITY_NONE;
      r_tick_cnt     <= '0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_par_err_pend <= 1'b0;
      r_result       <= '0;
      r_active       <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state        <= START;
            r_active       <= 1'b1;
            r_tick_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_par_err_pend <= 1'b0;
            r_baud         <= baud_e'(rx.baud_rate);
            r_parity       <= rx.parity_type;
          end
        end

        START: begin
          if (w_tick) begin
            if (r_tick_cnt == MID_TICK) begin
              r_tick_cnt <= '0;
              if (w_line) begin
                // Glitch: abandon quietly, keep previous byte and flags
                r_state  <= IDLE;
                r_active <= 1'b0;
              end else begin
                r_state <= DATA;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
        end

        DATA: begin
          if (w_tick) begin
            if (r_tick_cnt == LAST_TICK) begin
              r_tick_cnt <= '0;
              r_shift    <= {w_line, r_shift[DATA_W-1:1]};
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_state <= w_par_en ? PARITY : STOP;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
        end

        PARITY: begin
          if (w_tick) begin
            if (r_tick_cnt == LAST_TICK) begin
              r_tick_cnt     <= '0;
              r_par_err_pend <= (w_line != w_par_exp);
              r_state        <= STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
        end

        STOP: begin
          if (w_tick) begin
            if (r_tick_cnt == LAST_TICK) begin
              // Return at mid-stop so a following start edge is not missed
              r_tick_cnt            <= '0;
              r_result.data         <= r_shift;
              r_result.parity_error <= r_par_err_pend;
              r_result.stop_error   <= ~w_line;
              r_done                <= 1'b1;
              r_active              <= 1'b0;
              r_state               <= IDLE;
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
        end

        default: begin
          r_state  <= IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign rx.data_out     = r_result.data;
  assign rx.parity_error = r_result.parity_error;
  assign rx.stop_error   = r_result.stop_error;
  assign rx.active_flag  = r_active;
  assign rx.done_flag    = r_done;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Self-checking bench for uart_rx_unit: a frame-level transmitter model
// drives the line, a monitor collects done pulses, and expectations come
// from the frame rules (byte, parity bit count, stop bit level).
module tb_uart_rx_unit;

  localparam int unsigned CLK_FREQ = 650_000;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #10 clock = ~clock;

  uart_rx_unit_if bus ();

  uart_rx_unit #(
    .CLK_FREQ   (CLK_FREQ),
    .OVERSAMPLE (16)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rx      (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
  } frame_t;

  int     n_checks = 0;
  int     n_errors = 0;
  frame_t got_q[$];
  int     n_done = 0;
  int     n_dbl = 0;
  int     n_exp = 0;
  logic   prev_done = 1'b0;
  int     act_run = 0;
  int     last_act_len = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_perr = 1'b0;
  logic       last_serr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Clocks per bit: 16 ticks of truncated CLK/(16*baud)
  function automatic int unsigned bit_clocks(input logic [1:0] code);
    int unsigned baud;
    baud = 2400 * (1 << code);
    return 16 * (CLK_FREQ / (16 * baud));
  endfunction

  function automatic logic par_on(input logic [1:0] par);
    return (par == 2'b01) || (par == 2'b10);
  endfunction

  // Parity bit that makes the frame legal
  function automatic logic good_pbit(input logic [7:0] d, input logic [1:0] par);
    int ones;
    ones = $countones(d);
    if (par == 2'b01) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  function automatic logic exp_perr(input logic [7:0] d, input logic [1:0] par, input logic pbit);
    int ones;
    if (!par_on(par)) return 1'b0;
    ones = $countones(d) + int'(pbit);
    if (par == 2'b01) return (ones % 2) != 1;
    return (ones % 2) != 0;
  endfunction

  // Done-pulse and active-length monitor
  always @(negedge clock) begin
    if (bus.done_flag) begin
      n_done++;
      got_q.push_back('{bus.data_out, bus.parity_error, bus.stop_error});
      if (prev_done) n_dbl++;
    end
    prev_done = bus.done_flag;
    if (bus.active_flag) act_run++;
    else if (act_run != 0) begin
      last_act_len = act_run;
      act_run = 0;
    end
  end

  // Transmitter model; config is scrambled after the start bit to prove it is latched
  task automatic send_frame(input logic [7:0] d, input logic [1:0] baud, input logic [1:0] par,
                            input logic pbit, input logic sbit);
    int unsigned n;
    n = bit_clocks(baud);
    @(negedge clock);
    bus.baud_rate   = baud;
    bus.parity_type = par;
    bus.data_rx     = 1'b0;
    repeat (n) @(negedge clock);
    bus.baud_rate   = 2'($urandom);
    bus.parity_type = 2'($urandom);
    for (int i = 0; i < 8; i++) begin
      bus.data_rx = d[i];
      repeat (n) @(negedge clock);
    end
    if (par_on(par)) begin
      bus.data_rx = pbit;
      repeat (n) @(negedge clock);
    end
    bus.data_rx = sbit;
    repeat (n) @(negedge clock);
    bus.data_rx = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic perr, input logic serr);
    int waited;
    frame_t f;
    waited = 0;
    while (got_q.size() == 0 && waited < 64) begin
      @(negedge clock);
      waited++;
    end
    check({tag, "_done"}, 32'(got_q.size() != 0), 32'd1);
    if (got_q.size() != 0) begin
      f = got_q.pop_front();
      check({tag, "_data"}, 32'(f.data), 32'(d));
      check({tag, "_perr"}, 32'(f.perr), 32'(perr));
      check({tag, "_serr"}, 32'(f.serr), 32'(serr));
    end
  endtask

  task automatic send_and_check(input string tag, input logic [7:0] d, input logic [1:0] baud,
                                input logic [1:0] par, input logic pbit, input logic sbit);
    logic pe;
    pe = exp_perr(d, par, pbit);
    send_frame(d, baud, par, pbit, sbit);
    n_exp++;
    last_data = d;
    last_perr = pe;
    last_serr = ~sbit;
    expect_frame(tag, d, pe, ~sbit);
  endtask

  function automatic logic in_range(input int v, input int centre, input int tol);
    return (v >= centre - tol) && (v <= centre + tol);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n;
    int          pre_done;
    logic [7:0]  b;

    bus.data_rx     = 1'b1;
    bus.baud_rate   = 2'b00;
    bus.parity_type = 2'b00;
    repeat (3) @(negedge clock);
    check("rst_data",   32'(bus.data_out),     32'h0);
    check("rst_active", 32'(bus.active_flag),  32'h0);
    check("rst_done",   32'(bus.done_flag),    32'h0);
    check("rst_perr",   32'(bus.parity_error), 32'h0);
    check("rst_serr",   32'(bus.stop_error),   32'h0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // 9600 odd, 0xAA with legal parity 1; active spans 10.5 bits plus sync
    send_and_check("odd_aa", 8'hAA, 2'b10, 2'b01, 1'b1, 1'b1);
    n = bit_clocks(2'b10);
    check("odd_aa_active_len", 32'(in_range(last_act_len, int'(n * 21 / 2) + 2, int'(n / 16) + 4)), 32'd1);

    // 19200 even: legal then wrong parity bit
    send_and_check("even_ok",  8'h55, 2'b11, 2'b10, 1'b0, 1'b1);
    send_and_check("even_bad", 8'h55, 2'b11, 2'b10, 1'b1, 1'b1);

    // 2400 no parity with stop forced low; a parity slot would sample idle-high
    send_and_check("stop_err", 8'h3C, 2'b00, 2'b00, 1'b0, 1'b0);
    repeat (20) @(negedge clock);

    // False start: short glitch at 9600
    pre_done = n_done;
    n = bit_clocks(2'b10);
    bus.baud_rate   = 2'b10;
    bus.parity_type = 2'b01;
    bus.data_rx     = 1'b0;
    repeat (6) @(negedge clock);
    bus.data_rx = 1'b1;
    repeat (n) @(negedge clock);
    check("glitch_active_len", 32'(in_range(last_act_len, int'(n / 2) + 1, int'(n / 16) + 4)), 32'd1);
    check("glitch_active_now", 32'(bus.active_flag),  32'h0);
    check("glitch_no_done",    32'(n_done),           32'(pre_done));
    check("glitch_data",       32'(bus.data_out),     32'(last_data));
    check("glitch_perr",       32'(bus.parity_error), 32'(last_perr));
    check("glitch_serr",       32'(bus.stop_error),   32'(last_serr));

    // Reset during data bit 4 of a 9600 frame
    pre_done = n_done;
    b = 8'hE7;
    @(negedge clock);
    bus.data_rx = 1'b0;
    repeat (n) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      bus.data_rx = b[i];
      repeat ((i == 4) ? n / 2 : n) @(negedge clock);
    end
    check("pre_rst_active", 32'(bus.active_flag), 32'h1);
    reset_n = 1'b0;
    #1;
    check("async_rst_data",   32'(bus.data_out),     32'h0);
    check("async_rst_active", 32'(bus.active_flag),  32'h0);
    check("async_rst_perr",   32'(bus.parity_error), 32'h0);
    check("async_rst_serr",   32'(bus.stop_error),   32'h0);
    bus.data_rx = 1'b1;
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (8 * n) @(negedge clock);
    check("rst_abort_no_done", 32'(n_done), 32'(pre_done));
    send_and_check("post_rst", 8'h81, 2'b10, 2'b01, good_pbit(8'h81, 2'b01), 1'b1);

    // Back-to-back random frames at every baud/parity combination
    for (int bd = 0; bd < 4; bd++) begin
      for (int pt = 0; pt < 4; pt++) begin
        for (int k = 0; k < 2; k++) begin
          b = 8'($urandom);
          send_and_check($sformatf("loop_b%0d_p%0d_%0d", bd, pt, k), b, 2'(bd), 2'(pt),
                         good_pbit(b, 2'(pt)), 1'b1);
        end
      end
    end

    repeat (20) @(negedge clock);
    check("total_done", 32'(n_done), 32'(n_exp));
    check("done_single_cycle", 32'(n_dbl), 32'h0);
    check("no_stray_frames", 32'(got_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_unit.md
Name: uart_rx_unit

Overview:
- UART receiver; the counterpart of the team's TxUnit transmitter. Shares its baud_rate and parity_type encodings and its frame format.
- Oversamples the serial line at 16x baud, deframes start/8 data/optional parity/stop, and presents the byte with done and error flags.
- Sits between the board RX pin and the byte-level consumer logic.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- OVERSAMPLE, 16, sample ticks per bit. Fixed; other values are not supported.

Ports:
- clock  input  1  system clock. Rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data_rx  input  1  serial line. Asynchronous to clock. Idles high.
- parity_type  input  2  00 none, 01 odd, 10 even, 11 none.
- baud_rate  input  2  00 2400, 01 4800, 10 9600, 11 19200.
- data_out  output  8  last received byte.
- active_flag  output  1  high while a frame is being received.
- done_flag  output  1  one-clock pulse when a frame completes.
- parity_error  output  1  parity mismatch in the last frame.
- stop_error  output  1  stop bit sampled low (framing error) in the last frame.

Behaviour:
- Reset (async, reset_n=0):
  - data_out=0, all flags=0.
  - FSM returns to IDLE; counters are cleared.
  - Synchronizer flops are set to 1 (line idle).
  - Reset mid-frame abandons the frame silently; no done_flag is produced.
- Input sync: 2-flop synchronizer on data_rx. All logic uses the synchronized signal (2-clock latency).
- Tick divisor: DIV = CLK_FREQ/(16*baud), truncated.
  - At 50 MHz: 1302, 651, 325, 162.
  - The divisor counter is cleared on start detection so ticks align to the start edge.
- Config latch: baud_rate and parity_type are latched on start detection. Changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - A 1->0 transition on the synchronized line moves the FSM to START and sets active_flag=1.
  - A line held low (break) does not retrigger; a new frame requires a return high first.
- START:
  - Samples at tick 7, the mid-bit point (8th tick).
  - If the line is high, it is a false start: return to IDLE, active_flag=0, no other output changes.
  - Otherwise the tick counter restarts and the FSM enters DATA.
- DATA:
  - 8 bits, LSB first, each sampled at tick count 15 after the previous sample (mid-bit).
  - Bits shift into an internal register.
  - After bit 7 the FSM goes to PARITY if parity is enabled, else to STOP.
- PARITY:
  - Samples one bit.
  - Expected value: odd => XOR(data)^1; even => XOR(data).
  - The mismatch result is held internally until STOP.
- STOP: samples one bit. On the following clock:
  - data_out <= shift register, even when errors are present.
  - parity_error and stop_error are updated (stop_error=1 if the sample was 0).
  - done_flag=1 for exactly one clock.
  - active_flag=0; the FSM enters IDLE.
- Error flags hold until the next completed frame. They are not cleared by a false start.
- Latency, start edge to done_flag (9600, parity on): 11 bit times minus half a bit, ±1 tick, plus 2 sync clocks. This is about 1.094 ms.
- A new start edge is accepted immediately after return to IDLE, including mid stop bit. Back-to-back frames are not lost.

Decomposition:
- Shared package uart_pkg holds:
  - parity encodings: PARITY_NONE=2'b00, PARITY_ODD=2'b01, PARITY_EVEN=2'b10.
  - baud encodings: BAUD_2400..BAUD_19200.
  - FSM state enum.
  - a function returning DIV from CLK_FREQ and the baud code.
- The package is to be reused by TxUnit.
- One sub-module, uart_rx_tick_gen:
  - inputs: clock, reset_n, clear, baud code.
  - output: a one-clock tick pulse at 16x baud.

Test Plan:
- 9600, odd parity, send 0xAA with parity bit 1 and stop bit 1 -> data_out=8'hAA, done_flag pulses once, parity_error=0, stop_error=0, active_flag is high for ~1.09 ms.
- 19200, even parity, send 0x55 with parity bit 0 -> data_out=8'h55, no errors. Then send 0x55 with parity bit 1 -> parity_error=1, data_out=8'h55.
- 2400, no parity, send 0x3C with stop bit forced 0 -> stop_error=1, done_flag pulses, data_out=8'h3C; no parity slot is consumed.
- False start at 9600: a 2 us low glitch -> active_flag deasserts at ~52 us, no done_flag, data_out and error flags unchanged.
- Reset mid-frame: reset_n=0 during data bit 4 -> all outputs are 0 immediately (async). A following clean frame 0x81 is received correctly.
- Loopback with TxUnit at each baud/parity combination, random bytes, back-to-back frames -> every byte matches, no errors, no dropped frames.
